// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream arbiter: N_SRC sources share one output stream through
// a one-entry output register, with the winning source index tagged on m_tid.
module axis_rr_arbiter #(
    parameter int N_SRC    = 4,
    parameter int DATA_W   = 16,
    parameter int PKT_MODE = 1,
    parameter int ID_W     = $clog2(N_SRC)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [N_SRC-1:0]        s_tvalid,
    output logic [N_SRC-1:0]        s_tready,
    input  logic [N_SRC*DATA_W-1:0] s_tdata,
    input  logic [N_SRC-1:0]        s_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_W-1:0]       m_tdata,
    output logic                    m_tlast,
    output logic [ID_W-1:0]         m_tid,
    output logic                    busy
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]   last_gnt_q, last_gnt_d;
    logic [ID_W-1:0]   pick, scan_idx;
    logic              pick_vld;
    logic              mv_q, mv_d;
    logic              ml_q, ml_d;
    logic [DATA_W-1:0] md_q, md_d;
    logic [ID_W-1:0]   mid_q, mid_d;
    logic              load_en, accept, release_gnt;
    logic [DATA_W-1:0] src_data [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign src_data[i] = s_tdata[i*DATA_W +: DATA_W];
    end

    // Scan from the farthest candidate back toward last_gnt+1 so the nearest
    // requester is written last and wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        scan_idx = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            scan_idx = ID_W'((int'(last_gnt_q) + k) % N_SRC);
            if (s_tvalid[scan_idx]) begin
                pick     = scan_idx;
                pick_vld = 1'b1;
            end
        end
    end

    assign load_en     = !mv_q || m_tready;
    assign accept      = (state_q == GRANT) && load_en && s_tvalid[gnt_q];
    assign release_gnt = accept && ((PKT_MODE == 0) || s_tlast[gnt_q]);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_gnt) begin
                    state_d    = IDLE;
                    last_gnt_d = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register drains on its own, even after the FSM has returned to IDLE.
    always_comb begin
        mv_d  = mv_q;
        md_d  = md_q;
        ml_d  = ml_q;
        mid_d = mid_q;
        if (accept) begin
            mv_d  = 1'b1;
            md_d  = src_data[gnt_q];
            ml_d  = s_tlast[gnt_q];
            mid_d = gnt_q;
        end else if (load_en) begin
            mv_d = 1'b0;
        end
    end

    always_comb begin
        s_tready = '0;
        if (state_q == GRANT) s_tready[gnt_q] = load_en;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_gnt_q <= ID_W'(N_SRC - 1);
            mv_q       <= 1'b0;
            md_q       <= '0;
            ml_q       <= 1'b0;
            mid_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            mv_q       <= mv_d;
            md_q       <= md_d;
            ml_q       <= ml_d;
            mid_q      <= mid_d;
        end
    end

    assign m_tvalid = mv_q;
    assign m_tdata  = md_q;
    assign m_tlast  = ml_q;
    assign m_tid    = mid_q;
    assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomized + directed bench: a packet-mode and a beat-mode arbiter driven by
// queue-based sources and checked each cycle against a behavioural model.
module tb_axis_rr_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;
  localparam int PKT [2] = '{1, 0};

  typedef struct {logic [W-1:0] d; logic l; int gap;} beat_t;
  typedef struct {int id; logic [W-1:0] d; logic l; int cyc;} obs_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic rst_next = 1'b0;
  logic prev_rst = 1'b0;
  logic [N-1:0]   tv [2], tl [2], sr [2], hs [2];
  logic [N*W-1:0] td [2];
  logic           mr [2], mv [2], ml [2], bz [2];
  logic [W-1:0]   md [2];
  logic [IW-1:0]  mid [2];

  beat_t srcq [2][N][$];
  beat_t expq [2][N][$];
  obs_t  obs [2][$];
  int    wcnt [2][N];
  int    rpct [2];
  int    stall [2];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  // behavioural model state
  bit           mb [2];
  int           mg [2], mlast [2], moid [2];
  bit           mov [2], mol [2];
  logic [W-1:0] mod [2];

  always #5 aclk = ~aclk;

  axis_rr_arbiter #(.N_SRC(N), .DATA_W(W), .PKT_MODE(1)) dut_pkt (
    .aclk(aclk), .aresetn(aresetn), .s_tvalid(tv[0]), .s_tready(sr[0]), .s_tdata(td[0]),
    .s_tlast(tl[0]), .m_tvalid(mv[0]), .m_tready(mr[0]), .m_tdata(md[0]), .m_tlast(ml[0]),
    .m_tid(mid[0]), .busy(bz[0]));

  axis_rr_arbiter #(.N_SRC(N), .DATA_W(W), .PKT_MODE(0)) dut_beat (
    .aclk(aclk), .aresetn(aresetn), .s_tvalid(tv[1]), .s_tready(sr[1]), .s_tdata(td[1]),
    .s_tlast(tl[1]), .m_tvalid(mv[1]), .m_tready(mr[1]), .m_tdata(md[1]), .m_tlast(ml[1]),
    .m_tid(mid[1]), .busy(bz[1]));

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset(int k);
    mb[k] = 0; mg[k] = 0; mlast[k] = N - 1;
    mov[k] = 0; mod[k] = '0; mol[k] = 0; moid[k] = 0;
  endtask

  task automatic push_beat(int k, int s, logic [W-1:0] d, logic l, int gap);
    beat_t b;
    b.d = d; b.l = l; b.gap = gap;
    srcq[k][s].push_back(b);
  endtask

  // Sources present their queue heads; an accepted beat is popped and the next
  // one appears after its programmed number of idle cycles.
  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < N; s++) begin
        if (hs[k][s] && srcq[k][s].size() > 0) begin
          void'(srcq[k][s].pop_front());
          wcnt[k][s] = 0;
        end
        if (!aresetn && prev_rst) begin
          srcq[k][s].delete();
          wcnt[k][s] = 0;
        end
        if (srcq[k][s].size() > 0 && wcnt[k][s] >= srcq[k][s][0].gap) begin
          tv[k][s] = 1'b1;
          td[k][s*W +: W] = srcq[k][s][0].d;
          tl[k][s] = srcq[k][s][0].l;
        end else begin
          tv[k][s] = 1'b0;
          if (srcq[k][s].size() > 0) wcnt[k][s]++;
        end
      end
      if (stall[k] > 0) begin
        mr[k] = 1'b0;
        stall[k]--;
      end else begin
        mr[k] = ($urandom_range(0, 99) < rpct[k]);
      end
    end
    prev_rst = aresetn;
  endtask

  task automatic monitor();
    logic [N-1:0] exp_rdy;
    obs_t o;
    beat_t b;
    bit ld;
    int id;
    for (int k = 0; k < 2; k++) begin
      if (!aresetn) begin
        model_reset(k);
        for (int s = 0; s < N; s++) expq[k][s].delete();
      end
      exp_rdy = '0;
      if (mb[k] && (!mov[k] || mr[k])) exp_rdy[mg[k]] = 1'b1;
      n_cmp++;
      if (mv[k] !== mov[k] || md[k] !== mod[k] || ml[k] !== mol[k] || mid[k] !== IW'(moid[k]) ||
          bz[k] !== mb[k] || sr[k] !== exp_rdy) begin
        n_err++;
        if (n_err < 30)
          $display("FAIL cycle %0d dut%0d: got v%0b d%h l%0b id%0d busy%0b rdy%b, expected v%0b d%h l%0b id%0d busy%0b rdy%b",
                   cyc, k, mv[k], md[k], ml[k], mid[k], bz[k], sr[k],
                   mov[k], mod[k], mol[k], moid[k], mb[k], exp_rdy);
      end
      hs[k] = aresetn ? (tv[k] & sr[k]) : '0;
      if (aresetn) begin
        if (mv[k] && mr[k]) begin
          id = int'(mid[k]);
          n_cmp++;
          if (expq[k][id].size() == 0) begin
            n_err++;
            $display("FAIL scoreboard dut%0d: got beat %h from src %0d, expected none", k, md[k], id);
          end else begin
            b = expq[k][id].pop_front();
            if (b.d !== md[k] || b.l !== ml[k]) begin
              n_err++;
              $display("FAIL scoreboard dut%0d src%0d: got %h/%0b, expected %h/%0b", k, id, md[k], ml[k], b.d, b.l);
            end
          end
          o.id = id; o.d = md[k]; o.l = ml[k]; o.cyc = cyc;
          obs[k].push_back(o);
        end
        for (int s = 0; s < N; s++)
          if (hs[k][s]) begin
            b.d = td[k][s*W +: W]; b.l = tl[k][s]; b.gap = 0;
            expq[k][s].push_back(b);
          end
        // model: output register drains, granted source may load, IDLE arbitrates
        ld = !mov[k] || mr[k];
        if (mov[k] && mr[k]) mov[k] = 0;
        if (mb[k]) begin
          if (ld && tv[k][mg[k]]) begin
            mov[k] = 1; mod[k] = td[k][mg[k]*W +: W]; mol[k] = tl[k][mg[k]]; moid[k] = mg[k];
            if (PKT[k] == 0 || tl[k][mg[k]]) begin
              mb[k] = 0;
              mlast[k] = mg[k];
            end
          end
        end else begin
          for (int j = 1; j <= N; j++)
            if (tv[k][(mlast[k] + j) % N]) begin
              mg[k] = (mlast[k] + j) % N;
              mb[k] = 1;
              break;
            end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    drive();
    #1;
    monitor();
    @(posedge aclk);
    #3;
    aresetn = rst_next;
    cyc++;
  endtask

  task automatic do_reset();
    rpct[0] = 100; rpct[1] = 100; stall[0] = 0; stall[1] = 0;
    rst_next = 1'b0;
    tick(); tick();
    rst_next = 1'b1;
    tick();
    obs[0].delete(); obs[1].delete();
  endtask

  task automatic wait_obs(int k, int n, int budget);
    int t = 0;
    while (obs[k].size() < n && t < budget) begin
      tick();
      t++;
    end
    if (obs[k].size() < n) begin
      n_cmp++; n_err++;
      $display("FAIL timeout dut%0d: got %0d beats, expected %0d", k, obs[k].size(), n);
    end
  endtask

  task automatic check_log(int k, string nm, int cnt, int ids[10], int ds[10], int ls[10]);
    check({nm, " count"}, obs[k].size(), cnt);
    for (int i = 0; i < cnt && i < obs[k].size(); i++) begin
      check($sformatf("%s id[%0d]", nm, i), obs[k][i].id, ids[i]);
      check($sformatf("%s data[%0d]", nm, i), obs[k][i].d, ds[i]);
      check($sformatf("%s last[%0d]", nm, i), obs[k][i].l, ls[i]);
    end
  endtask

  function automatic bit all_done();
    for (int k = 0; k < 2; k++) begin
      if (mov[k]) return 0;
      for (int s = 0; s < N; s++)
        if (srcq[k][s].size() > 0 || expq[k][s].size() > 0) return 0;
    end
    return 1;
  endfunction

  initial begin
    int t;
    int len;
    for (int k = 0; k < 2; k++) begin
      tv[k] = '0; tl[k] = '0; td[k] = '0; hs[k] = '0; mr[k] = 1'b1;
      rpct[k] = 100; stall[k] = 0;
      model_reset(k);
      for (int s = 0; s < N; s++) wcnt[k][s] = 0;
    end

    // reset with every source requesting
    for (int s = 0; s < N; s++) push_beat(0, s, W'(16'hA0 + s), 1'b1, 0);
    tick(); tick();
    #1;
    check("rst m_tvalid", mv[0], 0);
    check("rst m_tdata", md[0], 0);
    check("rst m_tlast", ml[0], 0);
    check("rst m_tid", mid[0], 0);
    check("rst busy", bz[0], 0);
    check("rst s_tready", sr[0], 0);
    rst_next = 1'b1;
    tick();
    tick();
    check("post-rst busy", bz[0], 1);
    tick();
    check("post-rst m_tvalid", mv[0], 1);
    check("post-rst m_tid", mid[0], 0);
    check("post-rst m_tdata", md[0], 16'hA0);
    wait_obs(0, 4, 60);
    check_log(0, "rst", 4, '{0,1,2,3,0,0,0,0,0,0}, '{'hA0,'hA1,'hA2,'hA3,0,0,0,0,0,0},
              '{1,1,1,1,0,0,0,0,0,0});

    // round-robin packets, one bubble between grants
    do_reset();
    for (int s = 0; s < N; s++) begin
      push_beat(0, s, W'(16'h10 * s), 1'b0, 0);
      push_beat(0, s, W'(16'h10 * s + 1), 1'b1, 0);
    end
    push_beat(0, 0, 16'h02, 1'b0, 0);
    push_beat(0, 0, 16'h03, 1'b1, 0);
    wait_obs(0, 10, 80);
    check_log(0, "rr", 10, '{0,0,1,1,2,2,3,3,0,0}, '{'h00,'h01,'h10,'h11,'h20,'h21,'h30,'h31,'h02,'h03},
              '{0,1,0,1,0,1,0,1,0,1});
    for (int i = 1; i < 10 && i < obs[0].size(); i++)
      check($sformatf("rr gap[%0d]", i), obs[0][i].cyc - obs[0][i-1].cyc, (i % 2 == 1) ? 1 : 2);

    // backpressure mid-packet
    do_reset();
    for (int i = 0; i < 4; i++) push_beat(0, 2, W'(16'h20 + i), i == 3, 0);
    wait_obs(0, 1, 40);
    stall[0] = 3;
    tick();
    check("stall s_tready", sr[0], 0);
    check("stall m_tvalid", mv[0], 1);
    wait_obs(0, 4, 60);
    check_log(0, "bp", 4, '{2,2,2,2,0,0,0,0,0,0}, '{'h20,'h21,'h22,'h23,0,0,0,0,0,0},
              '{0,0,0,1,0,0,0,0,0,0});

    // grant lock while the owner stalls mid-packet
    do_reset();
    push_beat(0, 1, 16'h11, 1'b0, 0);
    push_beat(0, 1, 16'h12, 1'b0, 4);
    push_beat(0, 1, 16'h13, 1'b1, 0);
    push_beat(0, 2, 16'h21, 1'b1, 2);
    push_beat(0, 3, 16'h31, 1'b1, 2);
    wait_obs(0, 1, 40);
    check("lock busy", bz[0], 1);
    check("lock s_tready[3:2]", sr[0][3:2], 0);
    wait_obs(0, 5, 80);
    check_log(0, "lock", 5, '{1,1,1,2,3,0,0,0,0,0}, '{'h11,'h12,'h13,'h21,'h31,0,0,0,0,0},
              '{0,0,1,1,1,0,0,0,0,0});

    // beat mode alternates sources
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      push_beat(1, 0, W'(i), 1'b0, 0);
      push_beat(1, 2, W'(16'h20 + i), 1'b0, 0);
    end
    wait_obs(1, 6, 60);
    check_log(1, "beat", 6, '{0,2,0,2,0,2,0,0,0,0}, '{'h01,'h21,'h02,'h22,'h03,'h23,0,0,0,0},
              '{0,0,0,0,0,0,0,0,0,0});
    for (int i = 1; i < 6 && i < obs[1].size(); i++)
      check($sformatf("beat gap[%0d]", i), obs[1][i].cyc - obs[1][i-1].cyc, 2);

    // reset mid-packet abandons the packet and restores source 0 priority
    do_reset();
    push_beat(0, 0, 16'h51, 1'b0, 0);
    push_beat(0, 0, 16'h52, 1'b0, 0);
    push_beat(0, 0, 16'h53, 1'b1, 0);
    wait_obs(0, 1, 40);
    rst_next = 1'b0;
    aresetn = 1'b0;
    #1;
    check("midrst m_tvalid", mv[0], 0);
    check("midrst busy", bz[0], 0);
    tick(); tick();
    rst_next = 1'b1;
    tick();
    obs[0].delete();
    push_beat(0, 1, 16'h61, 1'b1, 0);
    push_beat(0, 0, 16'h71, 1'b1, 0);
    wait_obs(0, 2, 40);
    check_log(0, "midrst", 2, '{0,1,0,0,0,0,0,0,0,0}, '{'h71,'h61,0,0,0,0,0,0,0,0},
              '{1,1,0,0,0,0,0,0,0,0});

    // random traffic on both arbiters
    do_reset();
    rpct[0] = 70; rpct[1] = 60;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < N; s++)
        for (int p = 0; p < 8; p++) begin
          len = $urandom_range(1, 4);
          for (int i = 0; i < len; i++)
            push_beat(k, s, W'($urandom), (i == len - 1), $urandom_range(0, 3));
        end
    t = 0;
    while (!all_done() && t < 4000) begin
      tick();
      t++;
    end
    check("random drained", all_done(), 1);
    rpct[0] = 100; rpct[1] = 100;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
